// File: rtl/tt_ro_freq_reader.sv
// rtl/tt_ro_freq_reader.sv - ring-oscillator edge counter over a programmable gate window, read out bytewise.
// Optional trailing status byte {overflow, 4'b0, gate_sel} when TT_RO_STATUS_BYTE_EN is defined.
module tt_ro_freq_reader #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       ro_in,
  input  logic       start,
  input  logic [2:0] gate_sel,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, GATE, SEND_LO, SEND_HI, SEND_ST} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_pulse;
  logic [2:0]             gsel_q;
  logic [21:0]            win_cnt;
  logic [21:0]            win_last;
  logic [4:0]             win_shift;
  logic [CNT_W-1:0]       cnt;
  logic                   ovf;
  logic                   accept;
  logic                   win_done;

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign accept     = (state == IDLE) && start && ena;
  // Window is 2^(8+2*gsel) cycles; for gsel=7 the 23-bit length truncates to all-ones last index.
  assign win_shift  = 5'd8 + {1'b0, gsel_q, 1'b0};
  assign win_last   = 22'((23'd1 << win_shift) - 23'd1);
  assign win_done   = (win_cnt == win_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sync_q  <= '0;
      hist_q  <= 1'b0;
      gsel_q  <= '0;
      win_cnt <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else begin
      state  <= state_nx;
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      if (accept) begin
        gsel_q  <= gate_sel;
        win_cnt <= '0;
        cnt     <= '0;
        ovf     <= 1'b0;
      end else if (state == GATE) begin
        win_cnt <= win_cnt + 22'd1;
        if (edge_pulse) begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          else if (!ovf)      ovf <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    rd_valid = 1'b0;
    rd_data  = 8'h00;
    case (state)
      IDLE:    if (accept) state_nx = GATE;
      GATE:    if (win_done) state_nx = SEND_LO;
      SEND_LO: begin
        rd_valid = 1'b1;
        rd_data  = cnt[7:0];
        if (rd_ready) state_nx = SEND_HI;
      end
      SEND_HI: begin
        rd_valid = 1'b1;
        rd_data  = 8'(cnt >> 8);
`ifdef TT_RO_STATUS_BYTE_EN
        if (rd_ready) state_nx = SEND_ST;
`else
        if (rd_ready) state_nx = IDLE;
`endif
      end
`ifdef TT_RO_STATUS_BYTE_EN
      SEND_ST: begin
        rd_valid = 1'b1;
        rd_data  = {ovf, 4'b0000, gsel_q};
        if (rd_ready) state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tt_ro_freq_reader.sv
// tb/tb_tt_ro_freq_reader.sv - self-checking bench for tt_ro_freq_reader against an edge-timestamp model.
module tb_tt_ro_freq_reader;
  localparam int S  = 2;
  localparam int CW = 9;
  localparam int CMAX = (1 << CW) - 1;
`ifdef TT_RO_STATUS_BYTE_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic       clk = 1'b0;
  logic       rst, ena, ro_in, start, rd_ready;
  logic [2:0] gate_sel;
  logic [7:0] rd_data;
  logic       rd_valid, busy;

  tt_ro_freq_reader #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .ro_in(ro_in), .start(start),
    .gate_sel(gate_sel), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mode   = 0;  // 0 hold low, 1 hold high, 2 toggle, 3 random
  int rises[$];

  typedef struct {
    logic [2:0] g;
    int         md;
    int         stall;
    bit         restart;
    int         cmin;
    int         cmax;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, outputs are sampled there too.
  task automatic step();
    logic prev;
    @(posedge clk);
    cyc++;
    #1;
    prev = ro_in;
    case (mode)
      0:       ro_in = 1'b0;
      1:       ro_in = 1'b1;
      2:       ro_in = ~ro_in;
      default: ro_in = 1'($urandom_range(0, 1));
    endcase
    if (ro_in && !prev) rises.push_back(cyc);
  endtask

  // A rise driven in cycle c is counted at edge c+S+1; the window counts edges a+1 .. a+len.
  function automatic int model_raw(input int a, input int len);
    int n = 0;
    foreach (rises[i])
      if (rises[i] >= a - S && rises[i] <= a + len - S - 1) n++;
    return n;
  endfunction

  task automatic run_meas(input logic [2:0] g, input int md, input int stall,
                          input bit restart, output int cnt_obs);
    int a, len, raw, expc, p;
    bit ok, eovf;
    logic [7:0] b [3];
    logic [7:0] held;
    cnt_obs = -1;
    mode = md;
    rd_ready = 1'b0;
    repeat (4) step();
    gate_sel = g;
    start = 1'b1;
    step();
    a = cyc;
    start = 1'b0;
    gate_sel = 3'($urandom_range(0, 7));
    len = 1 << (8 + 2 * int'(g));
    ok = 1'b1;
    p = -1;
    for (int i = 0; i < len + 20; i++) begin
      if (rd_valid) begin
        p = cyc;
        break;
      end
      if (!busy || rd_data != 8'h00) ok = 1'b0;
      if (restart && i == 10) begin
        start = 1'b1;
        gate_sel = 3'd7;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk("gate_busy_zero_data", int'(ok), 1);
    chk("window_len", (p < 0) ? -1 : p - a, len);
    if (p < 0) return;
    for (int k = 0; k < NB; k++) begin
      held = rd_data;
      ok = 1'b1;
      for (int s = 0; s < stall; s++) begin
        step();
        if (!rd_valid || rd_data != held) ok = 1'b0;
      end
      if (stall > 0) chk("stall_hold", int'(ok), 1);
      chk("byte_valid", int'(rd_valid), 1);
      b[k] = rd_data;
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
    chk("idle_after_send", int'({busy, rd_valid}), 0);
    ok = 1'b1;
    repeat (5) begin
      step();
      if (rd_valid || rd_data != 8'h00) ok = 1'b0;
    end
    chk("no_extra_bytes", int'(ok), 1);
    raw  = model_raw(a, len);
    expc = (raw > CMAX) ? CMAX : raw;
    eovf = (raw > CMAX);
    chk("byte_lo", int'(b[0]), expc & 8'hFF);
    chk("byte_hi", int'(b[1]), expc >> 8);
`ifdef TT_RO_STATUS_BYTE_EN
    chk("byte_status", int'(b[2]), int'({eovf, 4'b0000, g}));
`else
    if (eovf) chk("model_sat", int'(b[0]) + 256 * int'(b[1]), CMAX);
`endif
    cnt_obs = int'(b[0]) + 256 * int'(b[1]);
  endtask

  initial begin
    vec_t vecs[$];
    int   cnt_obs;
    bit   ok;
    int   p;

    vecs.push_back('{3'd0, 0, 0,  1'b0, 0,   0});
    vecs.push_back('{3'd0, 2, 10, 1'b0, 127, 129});
    vecs.push_back('{3'd1, 2, 0,  1'b1, 511, 511});
    vecs.push_back('{3'd0, 1, 3,  1'b0, 0,   1});
    vecs.push_back('{3'd1, 3, 2,  1'b1, 0,   511});

    rst = 1'b1; ena = 1'b1; ro_in = 1'b0; start = 1'b0; rd_ready = 1'b0; gate_sel = 3'd0;
    mode = 0;
    repeat (3) step();
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_data", int'(rd_data), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (2) step();

    foreach (vecs[i]) begin
      run_meas(vecs[i].g, vecs[i].md, vecs[i].stall, vecs[i].restart, cnt_obs);
      chk("vec_range", int'(cnt_obs >= vecs[i].cmin && cnt_obs <= vecs[i].cmax), 1);
    end

    for (int r = 0; r < 6; r++)
      run_meas(3'($urandom_range(0, 1)), 3, $urandom_range(0, 3), 1'($urandom_range(0, 1)), cnt_obs);

    // Start with ena low must be ignored.
    mode = 0;
    ena = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    ok = 1'b1;
    repeat (300) begin
      if (busy || rd_valid) ok = 1'b0;
      step();
    end
    chk("ena_low_ignored", int'(ok), 1);
    ena = 1'b1;

    // Reset in the middle of GATE.
    gate_sel = 3'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (50) step();
    chk("busy_mid_gate", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_gate_busy_now", int'(busy), 0);
    step();
    rst = 1'b0;
    ok = 1'b1;
    repeat (400) begin
      if (rd_valid || busy) ok = 1'b0;
      step();
    end
    chk("rst_gate_no_output", int'(ok), 1);

    // Reset while the low byte is being offered.
    start = 1'b1;
    step();
    start = 1'b0;
    p = -1;
    for (int i = 0; i < 300; i++) begin
      if (rd_valid) begin
        p = i;
        break;
      end
      step();
    end
    chk("send_reached", int'(p >= 0), 1);
    rst = 1'b1;
    #1;
    chk("rst_send_valid_now", int'({busy, rd_valid}), 0);
    step();
    rst = 1'b0;
    rd_ready = 1'b1;
    ok = 1'b1;
    repeat (300) begin
      if (rd_valid) ok = 1'b0;
      step();
    end
    rd_ready = 1'b0;
    chk("rst_send_no_output", int'(ok), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
